// File: rtl/dahb_master.sv
// Data-side AHB-Lite master: posted stores through a small write buffer, loads ordered
// behind earlier stores, one non-pipelined single transfer on the bus at a time.
module dahb_master #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned BUF_AW    = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        DAHB_access,
    input  logic        DAHB_rd0_wr1,
    input  logic [3:0]  DAHB_byte_strobe,
    input  logic [31:0] DAHB_write_data,
    input  logic [31:0] DAHB_addr,
    output logic        DAHB_trans_buffer_full,
    output logic [31:0] DAHB_read_data,
    output logic        DAHB_read_data_valid,
    output logic        DAHB_bus_error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdData
    } state_e;

    localparam logic [BUF_AW-1:0] PtrOne  = BUF_AW'(1);
    localparam logic [BUF_AW:0]   CntOne  = (BUF_AW + 1)'(1);
    localparam logic [BUF_AW:0]   CntFull = (BUF_AW + 1)'(BUF_DEPTH - 1);
    localparam logic [1:0]        TransIdle   = 2'b00;
    localparam logic [1:0]        TransNonseq = 2'b10;

    state_e state_q, state_d;

    logic [31:0] buf_addr [BUF_DEPTH];
    logic [3:0]  buf_strb [BUF_DEPTH];
    logic [31:0] buf_data [BUF_DEPTH];

    logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [BUF_AW:0]   count_q, count_d;
    logic              full_q;

    logic              ld_pend_q;
    logic [31:0]       ld_addr_q;
    logic [3:0]        ld_strb_q;
    // Stores still buffered ahead of the pending load; the load may issue once this is zero.
    logic [BUF_AW:0]   ahead_q, ahead_d;

    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              berr_q;

    logic push, ld_req, pop, rd_done;
    logic [31:0] head_addr, head_data;
    logic [3:0]  head_strb;

    function automatic logic [2:0] size_of(input logic [3:0] strb);
        logic [2:0] sz;
        case (strb)
            4'b1111:          sz = 3'd2;
            4'b0011, 4'b1100: sz = 3'd1;
            default:          sz = 3'd0;
        endcase
        return sz;
    endfunction

    assign push    = DAHB_access & DAHB_rd0_wr1;
    assign ld_req  = DAHB_access & ~DAHB_rd0_wr1;
    assign pop     = (state_q == StWrData) & HREADY;
    assign rd_done = (state_q == StRdData) & HREADY;

    assign head_addr = buf_addr[rd_ptr_q];
    assign head_strb = buf_strb[rd_ptr_q];
    assign head_data = buf_data[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (!push && pop) begin
            count_d = count_q - CntOne;
        end
    end

    always_comb begin
        ahead_d = ahead_q;
        if (ld_req) begin
            ahead_d = pop ? count_q - CntOne : count_q;
        end else if (ld_pend_q && pop && ahead_q != '0) begin
            ahead_d = ahead_q - CntOne;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= DAHB_addr;
            buf_strb[wr_ptr_q] <= DAHB_byte_strobe;
            buf_data[wr_ptr_q] <= DAHB_write_data;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            ld_pend_q <= 1'b0;
            ld_addr_q <= '0;
            ld_strb_q <= '0;
            ahead_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_d;
            // One slot of headroom absorbs the store already in flight when full rises.
            full_q  <= (count_d >= CntFull);
            if (ld_req) begin
                ld_pend_q <= 1'b1;
                ld_addr_q <= DAHB_addr;
                ld_strb_q <= DAHB_byte_strobe;
            end else if (rd_done) begin
                ld_pend_q <= 1'b0;
            end
            ahead_q  <= ahead_d;
            rvalid_q <= rd_done;
            berr_q   <= (rd_done | pop) & HRESP;
            if (rd_done) begin
                rdata_q <= HRESP ? 32'h0 : HRDATA;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (ld_pend_q && ahead_q == '0) begin
                    state_d = StRdAddr;
                end else if (count_q != '0 || push) begin
                    state_d = StWrAddr;
                end else if (ld_req) begin
                    state_d = StRdAddr;
                end
            end
            StWrAddr: if (HREADY) state_d = StWrData;
            StWrData: if (HREADY) state_d = StIdle;
            StRdAddr: if (HREADY) state_d = StRdData;
            StRdData: if (HREADY) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        HTRANS = TransIdle;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
        HSIZE  = 3'd0;
        HWDATA = 32'h0;
        case (state_q)
            StWrAddr: begin
                HTRANS = TransNonseq;
                HWRITE = 1'b1;
                HADDR  = head_addr;
                HSIZE  = size_of(head_strb);
            end
            StWrData: HWDATA = head_data;
            StRdAddr: begin
                HTRANS = TransNonseq;
                HADDR  = ld_addr_q;
                HSIZE  = size_of(ld_strb_q);
            end
            default: ;
        endcase
    end

    assign HBURST                 = 3'b000;
    assign HPROT                  = 4'b0001;
    assign DAHB_trans_buffer_full = full_q;
    assign DAHB_read_data         = rdata_q;
    assign DAHB_read_data_valid   = rvalid_q;
    assign DAHB_bus_error         = berr_q;

endmodule
